// File: rtl/io_responder_if.sv
// Purpose : CPU-side memory-mapped IO bus between the CPU top and the board responder.
// Latency : reads are combinational (zero cycles); writes commit at the next clk edge.
// Backpressure: none; the responder always accepts a strobe in the cycle it is presented.
//
// Signals:
//   io_read  : CPU IO read strobe
//   io_write : CPU IO write strobe
//   io_addr  : register select (CPU address bits [3:2])
//   io_wdata : CPU write data
//   io_rdata : read data returned to the CPU
interface io_responder_if;
    logic        io_read;
    logic        io_write;
    logic [1:0]  io_addr;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;

    // CPU side
    modport master (
        output io_read,
        output io_write,
        output io_addr,
        output io_wdata,
        input  io_rdata
    );

    // Board responder side
    modport slave (
        input  io_read,
        input  io_write,
        input  io_addr,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/io_responder.sv
// Purpose : board-side IO responder: debounced switches, LED and 7-seg registers, sticky change flag.
// Latency : reads combinational (0 cycles); writes 1 cycle; switch step to SW update 2+DEBOUNCE_CYCLES.
// Backpressure: none; every read/write strobe is serviced in the cycle it is presented.
//
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : CPU IO bus (slave modport): io_read, io_write, io_addr, io_wdata -> io_rdata
//   sw_in     : raw asynchronous switches
//   led_out   : LED drive, active-high
//   seg_an    : digit enables, active-low
//   seg_cat   : cathodes {dp,g,f,e,d,c,b,a}, active-low
//
// Register map: 0 SW (RO), 1 LED (RW), 2 SEG (RW, digit i = SEG[4i+3:4i]), 3 STAT (RO, bit0 changed).
module io_responder #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SCAN_CYCLES     = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    io_responder_if.slave        bus,
    input  logic [23:0]          sw_in,
    output logic [23:0]          led_out,
    output logic [5:0]           seg_an,
    output logic [7:0]           seg_cat
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_LED  = 2'd1;
    localparam logic [1:0] ADDR_SEG  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    // ------------------------------------------------------------------
    // Switch synchroniser and debounce
    // ------------------------------------------------------------------
    logic [23:0]     r_sync1;
    logic [23:0]     r_sync2;
    logic [23:0]     r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_sync_moving;
    logic            w_db_load;

    // sync1 holds the value sync2 takes next; a mismatch means sync2 is
    // changing, so the stability count restarts in the same cycle sync2 moves.
    assign w_sync_moving = (r_sync1 != r_sync2);
    assign w_db_load     = !w_sync_moving && (r_sync2 != r_stable) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            if (w_sync_moving) begin
                r_db_cnt <= '0;
            end else if (r_sync2 != r_stable) begin
                if (w_db_load) begin
                    r_stable <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-visible registers
    // ------------------------------------------------------------------
    logic [23:0] r_led;
    logic [23:0] r_seg;
    logic        r_changed;
    logic [23:0] w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= '0;
            r_seg     <= '0;
            r_changed <= 1'b0;
        end else begin
            if (bus.io_write && (bus.io_addr == ADDR_LED)) r_led <= bus.io_wdata;
            if (bus.io_write && (bus.io_addr == ADDR_SEG)) r_seg <= bus.io_wdata;
            // A fresh switch update beats a simultaneous clear-on-read so no change is lost.
            if (w_db_load) begin
                r_changed <= 1'b1;
            end else if (bus.io_read && (bus.io_addr == ADDR_STAT)) begin
                r_changed <= 1'b0;
            end
        end
    end

    // Zero-latency read path; shows pre-write contents during a write cycle.
    always_comb begin
        w_rdata = '0;
        if (bus.io_read) begin
            case (bus.io_addr)
                ADDR_SW:   w_rdata = r_stable;
                ADDR_LED:  w_rdata = r_led;
                ADDR_SEG:  w_rdata = r_seg;
                default:   w_rdata = {23'd0, r_changed};
            endcase
        end
    end

    assign bus.io_rdata = w_rdata;
    assign led_out      = r_led;

    // ------------------------------------------------------------------
    // Seven-segment scanner
    // ------------------------------------------------------------------
    logic [SC_W-1:0] r_scan_cnt;
    logic [2:0]      r_digit;
    logic [5:0]      r_seg_an;
    logic [7:0]      r_seg_cat;
    logic [3:0]      w_nibble;
    logic [5:0]      w_an_next;
    logic [7:0]      w_cat_next;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    always_comb begin
        w_nibble = r_seg[3:0];
        case (r_digit)
            3'd1:    w_nibble = r_seg[7:4];
            3'd2:    w_nibble = r_seg[11:8];
            3'd3:    w_nibble = r_seg[15:12];
            3'd4:    w_nibble = r_seg[19:16];
            3'd5:    w_nibble = r_seg[23:20];
            default: w_nibble = r_seg[3:0];
        endcase
    end

    assign w_an_next  = ~(6'd1 << r_digit);
    assign w_cat_next = hex_to_seg(w_nibble);   // every code already has dp (bit7) off

    // Anode and cathode are registered from the same digit index in the same
    // edge, so they always switch together and no neighbour digit ghosts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
            r_seg_an   <= 6'b111110;
            r_seg_cat  <= 8'hC0;
        end else begin
            if (r_scan_cnt == SC_LAST) begin
                r_scan_cnt <= '0;
                r_digit    <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_seg_an  <= w_an_next;
            r_seg_cat <= w_cat_next;
        end
    end

    assign seg_an  = r_seg_an;
    assign seg_cat = r_seg_cat;

endmodule

// File: tb/tb_io_responder.sv
// Purpose : self-checking bench for io_responder: directed scenarios plus randomized traffic vs a reference model.
// Latency : model tracks 0-cycle reads, 1-cycle writes, 2+DEB switch debounce, registered scan outputs.
// Backpressure: none modelled; the DUT accepts every strobe.
module tb_io_responder;

    localparam int DEB  = 4;
    localparam int SCAN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sw_in;
    logic [23:0] led_out;
    logic [5:0]  seg_an;
    logic [7:0]  seg_cat;

    io_responder_if bus();

    io_responder #(.DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .sw_in   (sw_in),
        .led_out (led_out),
        .seg_an  (seg_an),
        .seg_cat (seg_cat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [7:0] CODES [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic [23:0] m_led, m_seg, m_stable;
    logic        m_changed;
    logic [5:0]  m_an;
    logic [7:0]  m_cat;
    int          m_j;          // edges since the last reset edge
    logic [23:0] m_hist[$];    // last DEB+1 switch samples, oldest first

    logic        d_rst, d_rd, d_wr;
    logic [1:0]  d_addr;
    logic [23:0] d_wdata, d_sw;

    function automatic logic [23:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return m_stable;
            2'd1:    return m_led;
            2'd2:    return m_seg;
            default: return {23'd0, m_changed};
        endcase
    endfunction

    // A switch value is accepted once it has been sampled DEB+1 times in a
    // row (two synchroniser stages eat one sample of the 2+DEB latency).
    task automatic model_edge();
        int   dg;
        logic load;
        if (d_rst) begin
            m_led = '0; m_seg = '0; m_stable = '0; m_changed = 1'b0; m_j = 0;
            m_an = 6'b111110; m_cat = 8'hC0;
            m_hist.delete();
            repeat (DEB + 1) m_hist.push_back(24'd0);
        end else begin
            dg    = (m_j / SCAN) % 6;
            m_an  = 6'(~(6'd1 << dg));
            m_cat = CODES[4'(m_seg >> (4 * dg))];
            load  = (m_hist[0] != m_stable);
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) load = 1'b0;
            if (load) begin
                m_stable  = m_hist[0];
                m_changed = 1'b1;
            end else if (d_rd && d_addr == 2'd3) begin
                m_changed = 1'b0;
            end
            if (d_wr && d_addr == 2'd1) m_led = d_wdata;
            if (d_wr && d_addr == 2'd2) m_seg = d_wdata;
            m_hist.push_back(d_sw);
            void'(m_hist.pop_front());
            m_j++;
        end
    endtask

    task automatic apply(input logic r, input logic rd, input logic wr, input logic [1:0] a,
                         input logic [23:0] wd, input logic [23:0] sw);
        d_rst = r; d_rd = rd; d_wr = wr; d_addr = a; d_wdata = wd; d_sw = sw;
        rst = r; bus.io_read = rd; bus.io_write = wr; bus.io_addr = a; bus.io_wdata = wd; sw_in = sw;
    endtask

    // Drive one cycle's inputs and compare every output against the model.
    task automatic drive(input logic r, input logic rd, input logic wr, input logic [1:0] a,
                         input logic [23:0] wd, input logic [23:0] sw);
        logic [23:0] e;
        apply(r, rd, wr, a, wd, sw);
        #1;
        e = rd ? m_reg(a) : 24'd0;
        check_val("io_rdata", bus.io_rdata, e);
        check_val("led_out",  led_out,      m_led);
        check_val("seg_an",   seg_an,       m_an);
        check_val("seg_cat",  seg_cat,      m_cat);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    logic [7:0]  disp_cat [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [23:0] pool [4]     = '{24'h000000, 24'h00F00F, 24'hFFFFFF, 24'h5A0C33};

    initial begin
        int          hold;
        int          k;
        logic [23:0] sw_cur;

        @(negedge clk);
        apply(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 24'd0);
        tick();

        // Reset held a second cycle, reset state visible
        drive(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 24'd0);
        check_val("rst_led", led_out, 24'd0);
        check_val("rst_an",  seg_an,  6'b111110);
        check_val("rst_cat", seg_cat, 8'hC0);
        tick();

        // LED write then readback
        drive(1'b0, 1'b0, 1'b1, 2'd1, 24'hA5A5A5, 24'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'd1, 24'd0, 24'd0);
        check_val("led_read", bus.io_rdata, 24'hA5A5A5);
        check_val("led_out",  led_out,      24'hA5A5A5);
        tick();

        // Glitch of 3 cycles must be rejected
        for (int c = 0; c < 11; c++) begin
            drive(1'b0, 1'b1, 1'b0, 2'd0, 24'd0, (c < 3) ? 24'hFFFFFF : 24'd0);
            check_val("glitch_sw", bus.io_rdata, 24'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 2'd3, 24'd0, 24'd0);
        check_val("glitch_stat", bus.io_rdata, 24'd0);
        tick();

        // Clean step accepted on cycle 6, STAT clear-on-read
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, 1'b0, 2'd0, 24'd0, 24'h00F00F);
            check_val("deb_sw", bus.io_rdata, (c < 6) ? 24'd0 : 24'h00F00F);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 2'd3, 24'd0, 24'h00F00F);
        check_val("stat_set", bus.io_rdata, 24'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'd3, 24'd0, 24'h00F00F);
        check_val("stat_clr", bus.io_rdata, 24'd0);
        tick();

        // Display scan from a fresh reset
        drive(1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 24'd0);
        tick();
        for (int c = 0; c < 22; c++) begin
            drive(1'b0, 1'b0, (c == 0), 2'd2, 24'h123456, 24'd0);
            if (c >= 2) begin
                k = ((c - 1) / 3) % 6;
                check_val("scan_cat", seg_cat, disp_cat[k]);
                check_val("scan_an",  seg_an,  6'(~(6'd1 << k)));
            end
            tick();
        end

        // Write to SW ignored
        drive(1'b0, 1'b0, 1'b1, 2'd0, 24'hFFFFFF, 24'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'd0, 24'd0, 24'd0);
        check_val("sw_ro", bus.io_rdata, 24'd0);
        tick();

        // STAT read on the debounce-update edge: set wins
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, (c >= 5), 1'b0, 2'd3, 24'd0, 24'h000123);
            if (c == 5) check_val("setwin_pre",  bus.io_rdata, 24'd0);
            if (c == 6) check_val("setwin_post", bus.io_rdata, 24'd1);
            if (c == 7) check_val("setwin_clr",  bus.io_rdata, 24'd0);
            tick();
        end

        // Read gating and read-during-write
        drive(1'b0, 1'b0, 1'b1, 2'd1, 24'h5A5A5A, 24'h000123);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd1, 24'd0, 24'h000123);
        check_val("rd_gate", bus.io_rdata, 24'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 2'd1, 24'h123456, 24'h000123);
        check_val("rw_old", bus.io_rdata, 24'h5A5A5A);
        tick();
        drive(1'b0, 1'b1, 1'b0, 2'd1, 24'd0, 24'h000123);
        check_val("rw_new", bus.io_rdata, 24'h123456);
        tick();

        // Reset with the debounce counter at 2: full period needed again
        for (int c = 0; c < 13; c++) begin
            drive((c == 4), 1'b1, 1'b0, 2'd0, 24'd0, 24'h0A0B0C);
            if (c >= 5) check_val("midrst_sw", bus.io_rdata, (c >= 11) ? 24'h0A0B0C : 24'd0);
            tick();
        end

        // Randomized traffic against the model
        hold   = 0;
        sw_cur = 24'h0A0B0C;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                sw_cur = pool[$urandom_range(0, 3)];
                hold   = $urandom_range(1, DEB + 3);
            end
            hold--;
            drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 24'($urandom), sw_cur);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
Board-side responder for the CPU's 24-bit memory-mapped IO port. It answers CPU IO reads with debounced switch data or register contents, and latches CPU IO writes into LED and seven-segment registers. It drives a 6-digit multiplexed seven-segment display and flags switch changes through a sticky status bit. It sits between the CPU top (io_rdata/io_wdata, ioRead/ioWrite, ALU-result address) and the FPGA pins.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a synced switch value is accepted.
SCAN_CYCLES, 50000, cycles each display digit stays lit.

Ports:
clk  in  1  system clock (same clock as the CPU datapath).
rst  in  1  synchronous, active-high reset.
io_read  in  1  CPU IO read strobe.
io_write  in  1  CPU IO write strobe.
io_addr  in  2  register select, taken from CPU address bits [3:2].
io_wdata  in  24  CPU write data.
io_rdata  out  24  read data to CPU.
sw_in  in  24  raw asynchronous switches.
led_out  out  24  LED drive, active-high.
seg_an  out  6  digit enables, active-low.
seg_cat  out  8  cathodes {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Register map:
  - 0 SW (read-only): debounced switch value.
  - 1 LED (R/W).
  - 2 SEG (R/W): 6 hex digits, digit i = SEG[4i+3:4i].
  - 3 STAT (read-only): bit0 = changed, bits 23:1 read as 0.
- Writes: when io_write=1, the register at io_addr takes io_wdata at the next clk edge. Writes to addr 0 or 3 are ignored.
- Reads: io_rdata is combinational with zero latency (the CPU is single-cycle).
  - io_read=1: io_rdata = selected register.
  - io_read=0: io_rdata = 0.
  - io_read and io_write both high: the write happens at the edge; io_rdata shows the pre-write value during that cycle.
- Clear-on-read: an edge where io_read=1 and io_addr=3 clears changed.
  - If a debounce update occurs on the same edge, set wins and changed stays 1.
- Synchroniser: sw_in passes through a 2-flop synchroniser (sync1, sync2).
- Debounce, one shared counter:
  - The counter resets to 0 when sync2 differs from its previous-cycle value.
  - Otherwise, while sync2 != stable, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, the next edge loads stable <= sync2, sets changed=1 and clears the counter.
  - When sync2 == stable, the counter holds at 0.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable.
  - From a clean input step to the stable update: 2 + DEBOUNCE_CYCLES cycles.
- Display scanner:
  - The scan counter counts 0..SCAN_CYCLES-1. On wrap, digit index d advances 0→1→…→5→0.
  - seg_an = ~(1<<d).
  - seg_cat = hex decode of SEG digit d, with dp always off (bit7=1).
  - Codes: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - seg_an and seg_cat are registered and update together, so no ghost digit appears.
  - A SEG write shows on the current digit from the next scan update at the latest, within SCAN_CYCLES cycles.
- Reset state, applied at the first edge with rst=1:
  - sync regs, stable, LED, SEG, changed, both counters, d = 0.
  - led_out=0, seg_an=6'b111110, seg_cat=8'hC0.
  - io_rdata=0 unless io_read is high.
- Reset mid-debounce: the pending change is discarded. After reset is released, the counter restarts and the full debounce period is required again.

Test Plan:
- Reset, LED write: DEBOUNCE_CYCLES=4, SCAN_CYCLES=3. Hold rst 2 cycles → led_out=0, seg_an=111110, seg_cat=C0. Then write addr1=0xA5A5A5 → led_out=0xA5A5A5 next cycle, and read addr1 returns 0xA5A5A5.
- Debounce accept: step sw_in 0→0x00F00F and hold → SW read returns 0 through cycle 5 and 0x00F00F from cycle 6. STAT read returns 1, the following STAT read returns 0.
- Glitch reject: pulse sw_in=0xFFFFFF for 3 cycles → SW stays 0 and changed stays 0.
- Display scan: write SEG=0x123456 → digit0 shows 6 (seg_cat=82, an=111110). Every 3 cycles it advances through 5(92), 4(99), 3(B0), 2(A4), 1(F9) and wraps to digit0.
- Ignored write, set-wins, read gating: write addr0=0xFFFFFF → SW unchanged. A STAT read on the same edge as a debounce update → changed=1 afterwards. io_read=0 → io_rdata=0.
- Mid-debounce reset: step sw_in, assert rst at counter=2 and release → stable=0, then the update occurs a full 2+4 cycles after release.
